ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the single data RAM port between two requesters.
  - Master 0: CPU memory-stage port.
  - Master 1: loader/DMA port, used for program load and debug access.
- Uses a req/gnt/rvalid handshake with a fixed two-cycle response latency.
- Default policy is fixed priority to master 0, with a starvation counter that guarantees master 1 progress.
- Sits between the CPU and the data RAM inside the minimal SoC top.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Byte-select width is DATA_W/8.
- MAX_WAIT, 4, number of consecutive lost cycles after which master 1 is forced to win. Must be 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 command valid
- m0_we  in  1  master 0 write enable
- m0_sel  in  DATA_W/8  master 0 byte selects
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_gnt  out  1  master 0 command accepted this cycle
- m0_rvalid  out  1  master 0 response valid
- m0_rdata  out  DATA_W  master 0 read data
- m0_stall  out  1  m0_req & ~m0_gnt, fed to the CPU pipeline stall
- m1_req, m1_we, m1_sel, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0_* ports, for master 1
- ram_ce  out  1  RAM chip enable
- ram_we  out  1  RAM write enable
- ram_sel  out  DATA_W/8  RAM byte selects
- ram_addr  out  ADDR_W  RAM address
- ram_data_o  out  DATA_W  RAM write data
- ram_data_i  in  DATA_W  RAM read data, valid the cycle after ram_ce

Behaviour:
- Grant is combinational in cycle t from req and the priority state. At most one gnt is high per cycle.
- A master holds its req and command stable until its gnt. It may present a new command in cycle t+1 (back-to-back).
- Cycle t+1: the accepted command is registered onto ram_ce=1, ram_we, ram_sel, ram_addr, ram_data_o.
  - When nothing is granted, ram_ce=0 and ram_we/sel/addr/data_o=0.
- Cycle t+2: owner rvalid=1 for exactly one cycle.
  - Applies to writes as well; write rvalid is the completion indication.
  - Owner rdata = ram_data_i for reads; 0 for writes and whenever rvalid=0.
- The response owner is tracked by a 2-stage owner pipeline (valid + id + we). Throughput is 1 transaction/cycle total.
- Fixed-priority mode:
  - wait_cnt (8 bits) increments when m1_req & ~m1_gnt and saturates at MAX_WAIT; it clears on m1_gnt.
  - If wait_cnt == MAX_WAIT, master 1 wins; otherwise master 0 wins when both request.
- Single requester is granted immediately, with no idle cycle.
- Masters are never granted without req. wait_cnt is unchanged when m1_req=0.
- Reset, synchronous active-high:
  - ram_ce/we/sel/addr/data_o=0.
  - Owner pipeline cleared, so in-flight responses are dropped and no rvalid follows reset.
  - wait_cnt=0 and last-granted=1.
  - gnt outputs are forced to 0 while reset=1.
- m0_stall is combinational and is 0 during reset.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_gnt register updates on every grant.
  - When both request, the master that was not last granted wins.
  - wait_cnt logic and MAX_WAIT are unused.
  - last_gnt resets to 1, so master 0 wins the first conflict.
- Undefined: fixed priority with the starvation counter, as in Behaviour.
- Ports and latency are identical in both builds.

Test Plan:
- Lone read: m0 read at addr 0x10 in cycle 0 with the RAM holding 0xDEADBEEF at that address.
  - Cycle 0: m0_gnt=1.
  - Cycle 1: ram_ce=1, ram_addr=0x10, ram_we=0.
  - Cycle 2: m0_rvalid=1, m0_rdata=0xDEADBEEF.
  - Cycle 2: m1_rvalid=0.
- Write then read, master 1:
  - Write 0x12345678, sel=4'b1111, addr 0x20, then read 0x20 on the next cycle.
  - Required: two back-to-back grants.
  - Required: rvalid in cycles 2 and 3, cycle-3 rdata=0x12345678.
- Starvation, fixed priority, MAX_WAIT=4: m0_req and m1_req held high continuously from cycle 0.
  - Grants: m0 in cycles 0-3, m1 in cycle 4, then m0 in 5-8, m1 in 9.
  - m0_stall=1 in cycles 4 and 9.
- Round-robin, ARB_RR_EN defined: both masters requesting continuously.
  - Grants alternate m0, m1, m0, m1 starting with m0.
  - rvalid alternates with 2-cycle offset.
- Reset mid-flight:
  - m0 granted in cycle 0, reset=1 in cycle 1.
  - Required: m0_rvalid=0 in cycle 2, ram_ce=0 in cycle 2, wait_cnt=0.
  - First grant after reset release behaves as a fresh transaction.
- Simultaneous request with wait_cnt < MAX_WAIT:
  - m0 write and m1 read in the same cycle.
  - Required: m0 granted, m1_stall-equivalent (m1_gnt=0), wait_cnt increments by 1.
  - m1 is granted next cycle if m0_req drops.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-master data RAM port arbiter with 2-cycle response; ARB_RR_EN selects round-robin instead of fixed priority with starvation counter
module ram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_stall,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_sel,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                ram_ce,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_sel,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_data_o,
  input  logic [DATA_W-1:0]   ram_data_i
);
  logic m1_win;
  logic s1_id;
  logic s2_valid;
  logic s2_id;
  logic s2_we;
  logic [DATA_W-1:0] rd;
`ifdef ARB_RR_EN
  logic last_gnt;
  always_ff @(posedge clk)
    if (reset) last_gnt <= 1'b1;
    else if (m0_gnt | m1_gnt) last_gnt <= m1_gnt;
  assign m1_win = m1_req & (~m0_req | ~last_gnt);
`else
  logic [7:0] wait_cnt;
  logic sat;
  assign sat = wait_cnt == 8'(MAX_WAIT);
  always_ff @(posedge clk)
    if (reset) wait_cnt <= '0;
    else if (m1_gnt) wait_cnt <= '0;
    else if (m1_req & ~sat) wait_cnt <= wait_cnt + 8'd1;
  assign m1_win = m1_req & (~m0_req | sat);
`endif
  always_comb begin
    m0_gnt = ~reset & m0_req & ~m1_win;
    m1_gnt = ~reset & m1_win;
    m0_stall = ~reset & m0_req & ~m0_gnt;
  end
  // Stage 1 is the RAM command itself; stage 2 tracks who owns the returning data.
  always_ff @(posedge clk)
    if (reset) begin
      ram_ce <= 1'b0;
      ram_we <= 1'b0;
      ram_sel <= '0;
      ram_addr <= '0;
      ram_data_o <= '0;
      s1_id <= 1'b0;
      s2_valid <= 1'b0;
      s2_id <= 1'b0;
      s2_we <= 1'b0;
    end else begin
      ram_ce <= m0_gnt | m1_gnt;
      ram_we <= m1_gnt ? m1_we : m0_gnt & m0_we;
      ram_sel <= m1_gnt ? m1_sel : m0_gnt ? m0_sel : '0;
      ram_addr <= m1_gnt ? m1_addr : m0_gnt ? m0_addr : '0;
      ram_data_o <= m1_gnt ? m1_wdata : m0_gnt ? m0_wdata : '0;
      s1_id <= m1_gnt;
      s2_valid <= ram_ce;
      s2_id <= s1_id;
      s2_we <= ram_we;
    end
  always_comb begin
    m0_rvalid = s2_valid & ~s2_id;
    m1_rvalid = s2_valid & s2_id;
    rd = s2_we ? '0 : ram_data_i;
    m0_rdata = m0_rvalid ? rd : '0;
    m1_rdata = m1_rvalid ? rd : '0;
  end
endmodule
